// File: rtl/sccb_config_sequencer.sv
// Table-driven OV7670 register loader: fetches (sub-address, value) rows from an
// external table and writes each one as a 3-phase SCCB frame, with 0xFF rows as delays.
`timescale 1ns/1ps
module sccb_config_sequencer #(
  parameter int         CLK_HZ    = 12_000_000,
  parameter int         SCCB_HZ   = 100_000,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         NUM_REGS  = 76,
  parameter int         IDX_W     = 7,
  parameter int         GAP_QTRS  = 4,
  parameter int         MS_CYCLES = CLK_HZ / 1000
) (
  input  logic             GLOBAL_CLK,
  input  logic             RESET,
  input  logic             START,
  output logic [IDX_W-1:0] TBL_INDEX,
  input  logic [7:0]       TBL_ADDR,
  input  logic [7:0]       TBL_VALUE,
  output logic             SIOC,
  output logic             SIOD_O,
  output logic             SIOD_OE,
  output logic             BUSY,
  output logic             CONFIG_FINISHED,
  output logic [2:0]       state_dbg
);

  localparam int QTR = CLK_HZ / (4 * SCCB_HZ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START_C, S_BITS, S_STOP_C, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t         state, state_n;
  logic [QW-1:0]  q_cnt;
  logic [7:0]     q_idx;
  logic [4:0]     bit_cnt;
  logic [31:0]    cyc_cnt;
  logic [31:0]    dly_target;
  logic [26:0]    shreg;
  logic [7:0]     val_r;
  logic           qtr_end, last_row, row_adv, enter, fetch_end;
  logic           sioc_n, oe_n;

  assign qtr_end    = (q_cnt == QW'(QTR - 1));
  assign last_row   = (TBL_INDEX == IDX_W'(NUM_REGS - 1));
  assign fetch_end  = (state == S_FETCH) && (cyc_cnt == 32'd1);
  assign dly_target = 32'(val_r) * 32'(MS_CYCLES);
  assign SIOD_O     = 1'b0;
  assign state_dbg  = state;

  // START is a one-cycle request with no ready signal: it is accepted only in IDLE
  // (BUSY=0) on a cycle without RESET, and silently dropped otherwise.
  always_comb begin
    state_n = state;
    row_adv = 1'b0;
    case (state)
      S_IDLE:    if (START) state_n = S_FETCH;
      S_FETCH: begin
        if (cyc_cnt == 32'd1) begin
          if (TBL_ADDR != 8'hFF)       state_n = S_START_C;
          else if (TBL_VALUE != 8'd0)  state_n = S_DELAY;
          else                         row_adv = 1'b1;
        end
      end
      S_DELAY:   if (cyc_cnt == dly_target - 32'd1) row_adv = 1'b1;
      S_START_C: if (qtr_end && q_idx == 8'd1) state_n = S_BITS;
      S_BITS:    if (qtr_end && q_idx == 8'd3 && bit_cnt == 5'd26) state_n = S_STOP_C;
      S_STOP_C:  if (qtr_end && q_idx == 8'd2) state_n = S_GAP;
      S_GAP:     if (qtr_end && q_idx == 8'(GAP_QTRS - 1)) row_adv = 1'b1;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (row_adv) state_n = last_row ? S_DONE : S_FETCH;
    // A zero-delay row can go FETCH -> FETCH, so re-entry is flagged explicitly.
    enter = (state_n != state) || row_adv;

    sioc_n = 1'b1;
    oe_n   = 1'b0;
    case (state)
      S_START_C: begin
        sioc_n = (q_idx == 8'd0);
        oe_n   = 1'b1;
      end
      S_BITS: begin
        sioc_n = (q_idx == 8'd1) || (q_idx == 8'd2);
        oe_n   = ~shreg[26];
      end
      S_STOP_C: begin
        sioc_n = (q_idx != 8'd0);
        oe_n   = (q_idx != 8'd2);
      end
      default: begin
        sioc_n = 1'b1;
        oe_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      state           <= S_IDLE;
      q_cnt           <= '0;
      q_idx           <= 8'd0;
      bit_cnt         <= 5'd0;
      cyc_cnt         <= 32'd0;
      shreg           <= '0;
      val_r           <= 8'd0;
      TBL_INDEX       <= '0;
      BUSY            <= 1'b0;
      CONFIG_FINISHED <= 1'b0;
      SIOC            <= 1'b1;
      SIOD_OE         <= 1'b0;
    end else begin
      state <= state_n;
      if (enter) begin
        q_cnt   <= '0;
        q_idx   <= 8'd0;
        bit_cnt <= 5'd0;
        cyc_cnt <= 32'd0;
      end else begin
        cyc_cnt <= cyc_cnt + 32'd1;
        if (qtr_end) begin
          q_cnt <= '0;
          if (state == S_BITS && q_idx == 8'd3) begin
            q_idx   <= 8'd0;
            bit_cnt <= bit_cnt + 5'd1;
            shreg   <= {shreg[25:0], 1'b1};
          end else begin
            q_idx <= q_idx + 8'd1;
          end
        end else begin
          q_cnt <= q_cnt + QW'(1);
        end
      end

      if (state == S_IDLE && START) begin
        BUSY            <= 1'b1;
        CONFIG_FINISHED <= 1'b0;
        TBL_INDEX       <= '0;
      end
      // Ninth slot of each phase is a released bit, so the ACK slot never drives.
      if (fetch_end) begin
        val_r <= TBL_VALUE;
        shreg <= {DEV_ADDR, 1'b1, TBL_ADDR, 1'b1, TBL_VALUE, 1'b1};
      end
      if (row_adv && !last_row) TBL_INDEX <= TBL_INDEX + IDX_W'(1);
      if (state == S_DONE) begin
        BUSY            <= 1'b0;
        CONFIG_FINISHED <= 1'b1;
        TBL_INDEX       <= '0;
      end

      SIOC    <= sioc_n;
      SIOD_OE <= oe_n;
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: two instances (single write row; delay/write/zero-delay
// table) with a bus decoder that checks every decoded frame against an expected-byte queue.
`timescale 1ns/1ps
module tb_sccb_config_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: one write row, QTR=10
  logic       a_rst, a_start, a_sioc, a_siod_o, a_oe, a_busy, a_cf;
  logic [0:0] a_idx;
  logic [7:0] a_addr, a_val;
  logic [2:0] a_state;
  // Instance B: {FF,02},{11,01},{FF,00}, QTR=10, MS_CYCLES=100
  logic       b_rst, b_start, b_sioc, b_siod_o, b_oe, b_busy, b_cf;
  logic [1:0] b_idx;
  logic [7:0] b_addr, b_val;
  logic [2:0] b_state;

  sccb_config_sequencer #(
    .CLK_HZ(4_000_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
    .NUM_REGS(1), .IDX_W(1), .GAP_QTRS(4), .MS_CYCLES(4000)
  ) dut_a (
    .GLOBAL_CLK(clk), .RESET(a_rst), .START(a_start), .TBL_INDEX(a_idx),
    .TBL_ADDR(a_addr), .TBL_VALUE(a_val), .SIOC(a_sioc), .SIOD_O(a_siod_o),
    .SIOD_OE(a_oe), .BUSY(a_busy), .CONFIG_FINISHED(a_cf), .state_dbg(a_state)
  );

  sccb_config_sequencer #(
    .CLK_HZ(4_000_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
    .NUM_REGS(3), .IDX_W(2), .GAP_QTRS(4), .MS_CYCLES(100)
  ) dut_b (
    .GLOBAL_CLK(clk), .RESET(b_rst), .START(b_start), .TBL_INDEX(b_idx),
    .TBL_ADDR(b_addr), .TBL_VALUE(b_val), .SIOC(b_sioc), .SIOD_O(b_siod_o),
    .SIOD_OE(b_oe), .BUSY(b_busy), .CONFIG_FINISHED(b_cf), .state_dbg(b_state)
  );

  // Registered table ROMs: data valid one cycle after the index changes
  logic [7:0] rom_b_addr [4];
  logic [7:0] rom_b_val  [4];
  initial begin
    rom_b_addr[0] = 8'hFF; rom_b_val[0] = 8'h02;
    rom_b_addr[1] = 8'h11; rom_b_val[1] = 8'h01;
    rom_b_addr[2] = 8'hFF; rom_b_val[2] = 8'h00;
    rom_b_addr[3] = 8'h00; rom_b_val[3] = 8'h00;
  end
  always @(posedge clk) begin
    a_addr <= (a_idx == 1'b0) ? 8'h12 : 8'h00;
    a_val  <= (a_idx == 1'b0) ? 8'h80 : 8'h00;
    b_addr <= rom_b_addr[b_idx];
    b_val  <= rom_b_val[b_idx];
  end

  int tests = 0;
  int fails = 0;
  int od_viol = 0;
  int bad_evt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus decoder state, one slot per instance
  logic        pc   [2] = '{1'b1, 1'b1};
  logic        pd   [2] = '{1'b1, 1'b1};
  logic        prst [2] = '{1'b1, 1'b1};
  logic        act  [2] = '{1'b0, 1'b0};
  int          nb   [2] = '{0, 0};
  logic [27:0] fr   [2];
  int          frames [2] = '{0, 0};

  task automatic frame_check(input int i);
    logic [27:0] f;
    logic [7:0]  e;
    f = fr[i];
    check($sformatf("frame%0d_bits", i), nb[i], 28);
    for (int j = 0; j < 3; j++) begin
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check($sformatf("frame%0d_byte%0d", i, j), {24'd0, f[27-9*j -: 8]}, {24'd0, e});
    end
    check($sformatf("frame%0d_ack_released", i), {29'd0, f[19], f[10], f[1]}, 32'd7);
    frames[i]++;
  endtask

  task automatic mon_step(input int i, input logic c, input logic d, input logic rst);
    if (rst || prst[i]) begin
      act[i] = 1'b0;
    end else begin
      if (d != pd[i]) begin
        if (c != pc[i]) bad_evt++;
        else if (c) begin
          if (!d && !act[i]) begin
            act[i] = 1'b1; nb[i] = 0; fr[i] = '0;
          end else if (d && act[i]) begin
            act[i] = 1'b0;
            frame_check(i);
          end else bad_evt++;
        end
      end
      if (c && !pc[i] && act[i]) begin
        fr[i] = {fr[i][26:0], d};
        nb[i]++;
      end
    end
    pc[i] = c; pd[i] = d; prst[i] = rst;
  endtask

  always @(negedge clk) begin
    #1;
    mon_step(0, a_sioc, a_oe ? a_siod_o : 1'b1, a_rst);
    mon_step(1, b_sioc, b_oe ? b_siod_o : 1'b1, b_rst);
    if (a_siod_o && a_oe) od_viol++;
    if (b_siod_o && b_oe) od_viol++;
  end

  task automatic push_frame(input logic [7:0] sub, input logic [7:0] val);
    exp_q.push_back(8'h42);
    exp_q.push_back(sub);
    exp_q.push_back(val);
  endtask

  task automatic pulse_a();
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
  endtask

  task automatic pulse_b();
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
  endtask

  task automatic wait_idle_b(inout int k);
    while (b_busy && k < 5000) begin
      @(negedge clk); k++;
    end
  endtask

  initial begin
    int k;
    int quiet;
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_a_sioc", a_sioc, 1);
    check("rst_a_oe", a_oe, 0);
    check("rst_a_siod_o", a_siod_o, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_cf", a_cf, 0);
    check("rst_a_idx", a_idx, 0);
    check("rst_a_state", a_state, 0);
    check("rst_b_sioc", b_sioc, 1);
    check("rst_b_oe", b_oe, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_idx", b_idx, 0);

    // A: single write row; busy = FETCH 2 + 117 quarters * 10 + DONE 1
    push_frame(8'h12, 8'h80);
    pulse_a();
    check("a1_busy_rise", a_busy, 1);
    check("a1_cf_low", a_cf, 0);
    k = 0;
    while (a_busy && k < 3000) begin @(negedge clk); k++; end
    check("a1_busy_len", k, 1173);
    check("a1_cf_set", a_cf, 1);
    check("a1_idx_zero", a_idx, 0);
    check("a1_frames", frames[0], 1);

    // A: replay after finish, with a START pulse in the middle of the frame
    push_frame(8'h12, 8'h80);
    pulse_a();
    check("a2_cf_clear", a_cf, 0);
    check("a2_busy_rise", a_busy, 1);
    k = 0;
    while (a_busy && k < 3000) begin
      @(negedge clk); k++;
      if (k == 500) a_start = 1'b1;
      if (k == 501) begin
        a_start = 1'b0;
        check("a2_mid_idx", a_idx, 0);
        check("a2_mid_busy", a_busy, 1);
        check("a2_mid_cf", a_cf, 0);
      end
    end
    check("a2_busy_len", k, 1173);
    check("a2_cf_set", a_cf, 1);
    check("a2_frames", frames[0], 2);

    // B: 2 ms delay (200 cycles) with an idle bus, one write, zero-delay row
    push_frame(8'h11, 8'h01);
    pulse_b();
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_sioc !== 1'b1 || b_oe !== 1'b0) quiet++;
    end
    check("b1_delay_quiet", quiet, 0);
    check("b1_idx_in_delay", b_idx, 0);
    repeat (3) @(negedge clk);
    check("b1_idx_row1", b_idx, 1);
    k = 203;
    wait_idle_b(k);
    check("b1_busy_len", k, 1377);
    check("b1_cf_set", b_cf, 1);
    check("b1_idx_zero", b_idx, 0);
    check("b1_frames", frames[1], 1);

    // B: reset during BITS of row 1, START held in the reset cycle, then restart
    push_frame(8'h11, 8'h01);
    pulse_b();
    repeat (399) @(negedge clk);
    check("b2_idx_row1", b_idx, 1);
    b_rst = 1'b1; b_start = 1'b1;
    @(negedge clk);
    b_rst = 1'b0; b_start = 1'b0;
    check("b2_abort_sioc", b_sioc, 1);
    check("b2_abort_oe", b_oe, 0);
    check("b2_abort_busy", b_busy, 0);
    check("b2_abort_idx", b_idx, 0);
    check("b2_abort_cf", b_cf, 0);
    repeat (2) @(negedge clk);
    check("b2_start_with_reset_ignored", b_busy, 0);
    exp_q.delete();
    push_frame(8'h11, 8'h01);
    pulse_b();
    check("b3_busy_rise", b_busy, 1);
    check("b3_idx_row0", b_idx, 0);
    k = 0;
    wait_idle_b(k);
    check("b3_busy_len", k, 1377);
    check("b3_cf_set", b_cf, 1);
    check("b3_frames", frames[1], 2);

    repeat (5) @(negedge clk);
    check("open_drain_violations", od_viol, 0);
    check("siod_change_while_sioc_high", bad_evt, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
